// File: rtl/prog_mem_loader.sv
// Program/data memory for the SEL0628 core with a two-wire serial byte loader
// and a memory-mapped output register mirroring OUT_ADDR.
module prog_mem_loader #(
    parameter int         DEPTH    = 64,
    parameter logic [5:0] OUT_ADDR = 6'h3F
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       ld_mode,
    input  logic       ser_clk,
    input  logic       ser_data,
    input  logic [5:0] cpu_addr,
    input  logic       cpu_we,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_clr_n,
    output logic [7:0] out_port,
    output logic [6:0] load_cnt,
    output logic       loading
);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t state, state_nx;

    logic [1:0] ld_sync, sck_sync, sd_sync;
    logic       sck_d;
    logic       ld_s, sck_s, sd_s, sck_rise;
    logic       load_enter, byte_done, out_wr;

    // Only the low seven bits of the shifted history are ever part of a byte.
    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic [5:0] load_ptr;

    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] mem [DEPTH];

    assign ld_s     = ld_sync[1];
    assign sck_s    = sck_sync[1];
    assign sd_s     = sd_sync[1];
    assign sck_rise = sck_s & ~sck_d;
    assign loading  = ld_s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ld_sync   <= '0;
            sck_sync  <= '0;
            sd_sync   <= '0;
            sck_d     <= 1'b0;
            cpu_clr_n <= 1'b0;
        end else begin
            ld_sync   <= {ld_sync[0], ld_mode};
            sck_sync  <= {sck_sync[0], ser_clk};
            sd_sync   <= {sd_sync[0], ser_data};
            sck_d     <= sck_s;
            cpu_clr_n <= ~ld_s;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= RUN;
        else        state <= state_nx;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        load_enter = 1'b0;
        case (state)
            RUN: begin
                if (ld_s) begin
                    state_nx   = LOAD;
                    load_enter = 1'b1;
                end
            end
            LOAD: begin
                if (!ld_s) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    assign byte_done = ld_s & ~load_enter & sck_rise & (bit_cnt == 3'd7);

    // A partial byte left when ld_s falls is simply never written; entry clears it.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shift    <= '0;
            bit_cnt  <= '0;
            load_ptr <= '0;
            load_cnt <= '0;
        end else if (load_enter) begin
            shift    <= '0;
            bit_cnt  <= '0;
            load_ptr <= '0;
            load_cnt <= '0;
        end else if (ld_s && sck_rise) begin
            shift   <= {shift[5:0], sd_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                load_ptr <= load_ptr + 6'd1;
                if (load_cnt != 7'd64) load_cnt <= load_cnt + 7'd1;
            end
        end
    end

    // The core writes only while ld_s is low, which also drops a write on the ld_s rising cycle.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cpu_addr;
        wr_data = cpu_wdata;
        if (ld_s) begin
            if (byte_done) begin
                wr_en   = 1'b1;
                wr_addr = load_ptr;
                wr_data = {shift, sd_s};
            end
        end else if (cpu_we) begin
            wr_en = 1'b1;
        end
    end

    assign out_wr = ~ld_s & cpu_we & (cpu_addr == OUT_ADDR);

    // NOTE: the array is built from resettable flops so clr_n can clear every word at once.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)      out_port <= '0;
        else if (out_wr) out_port <= cpu_wdata;
    end

    assign cpu_rdata = mem[cpu_addr];

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: transaction-level memory model plus
// a per-cycle compare process and literal expectations from the test plan.
module tb_prog_mem_loader;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       ld_mode;
    logic       ser_clk;
    logic       ser_data;
    logic [5:0] cpu_addr;
    logic       cpu_we;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_clr_n;
    logic [7:0] out_port;
    logic [6:0] load_cnt;
    logic       loading;

    prog_mem_loader #(.DEPTH(64), .OUT_ADDR(6'h3F)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .ld_mode   (ld_mode),
        .ser_clk   (ser_clk),
        .ser_data  (ser_data),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_clr_n (cpu_clr_n),
        .out_port  (out_port),
        .load_cnt  (load_cnt),
        .loading   (loading)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_mem [64];
    logic [7:0] model_out;
    int         model_cnt;
    int         model_ptr;
    logic       model_loading;
    logic       cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && clr_n) begin
            check("cmp_rdata", cpu_rdata, model_mem[cpu_addr]);
            check("cmp_out_port", out_port, model_out);
            check("cmp_load_cnt", load_cnt, model_cnt);
            check("cmp_loading", loading, model_loading);
            check("cmp_cpu_clr_n", cpu_clr_n, !model_loading);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
        model_out     = 8'h00;
        model_cnt     = 0;
        model_ptr     = 0;
        model_loading = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        ser_data = b;
        tick(5);
        ser_clk = 1'b1;
        tick(5);
        ser_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cmp_en = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        tick(5);
        model_mem[model_ptr] = b;
        model_ptr = (model_ptr + 1) % 64;
        if (model_cnt < 64) model_cnt++;
        cmp_en = 1'b1;
    endtask

    task automatic set_ld(input logic v);
        int n;
        cmp_en  = 1'b0;
        ld_mode = v;
        if (v) begin
            tick(6);
            model_loading = 1'b1;
            model_cnt     = 0;
            model_ptr     = 0;
        end else begin
            n = 99;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (cpu_clr_n) begin
                    n = i;
                    break;
                end
            end
            check("clr_release_in_3_to_4", (n >= 3 && n <= 4) ? n : 32'hBAD, n);
            tick(2);
            model_loading = 1'b0;
        end
        cmp_en = 1'b1;
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tick(1);
        cpu_we = 1'b0;
        if (!model_loading) begin
            model_mem[a] = d;
            if (a == 6'h3F) model_out = d;
        end
    endtask

    task automatic check_mem(input logic [5:0] a, input logic [7:0] exp);
        cpu_addr = a;
        #1;
        check($sformatf("mem[%02h]", a), cpu_rdata, exp);
    endtask

    task automatic sweep();
        for (int a = 0; a < 64; a++) begin
            cpu_addr = a[5:0];
            tick(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n     = 1'b0;
        ld_mode   = 1'b0;
        ser_clk   = 1'b0;
        ser_data  = 1'b0;
        cpu_addr  = 6'h00;
        cpu_we    = 1'b0;
        cpu_wdata = 8'h00;
        model_clear();
        tick(3);

        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_cpu_clr_n", cpu_clr_n, 1'b0);
        check("rst_out_port", out_port, 8'h00);
        check("rst_load_cnt", load_cnt, 7'd0);
        check("rst_loading", loading, 1'b0);

        clr_n = 1'b1;
        tick(5);
        check("run_cpu_clr_n", cpu_clr_n, 1'b1);
        cmp_en = 1'b1;

        // Output port and ordinary core writes.
        cpu_write(6'h3F, 8'h5A);
        check("out_port_after_write", out_port, 8'h5A);
        check_mem(6'h3F, 8'h5A);
        cpu_write(6'h10, 8'h77);
        sweep();

        // Basic load with a blocked core write in the middle.
        set_ld(1'b1);
        check("load_cpu_clr_n", cpu_clr_n, 1'b0);
        send_byte(8'hC5);
        send_byte(8'h01);
        send_byte(8'hA3);
        cpu_write(6'h10, 8'hEE);
        sweep();
        check("load_cpu_clr_n_end", cpu_clr_n, 1'b0);
        set_ld(1'b0);
        check_mem(6'h00, 8'hC5);
        check_mem(6'h01, 8'h01);
        check_mem(6'h02, 8'hA3);
        check_mem(6'h10, 8'h77);
        check("basic_load_cnt", load_cnt, 7'd3);
        check("basic_out_port", out_port, 8'h5A);

        // Reset asserted after three bits of the second byte.
        set_ld(1'b1);
        send_byte(8'h11);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        cmp_en = 1'b0;
        clr_n  = 1'b0;
        tick(1);
        model_clear();
        check("midrst_out_port", out_port, 8'h00);
        check("midrst_load_cnt", load_cnt, 7'd0);
        check("midrst_cpu_clr_n", cpu_clr_n, 1'b0);
        for (int a = 0; a < 64; a++) check_mem(a[5:0], 8'h00);
        clr_n = 1'b1;
        tick(6);
        model_loading = 1'b1;
        cmp_en = 1'b1;

        // Partial byte after a full one: restart lands at address 0.
        send_byte(8'h55);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        set_ld(1'b0);
        check_mem(6'h00, 8'h55);
        check_mem(6'h01, 8'h00);
        check("partial_load_cnt", load_cnt, 7'd1);
        sweep();

        // Wrap and saturation; loader write to 0x3F must leave out_port alone.
        cpu_write(6'h3F, 8'hA5);
        set_ld(1'b1);
        for (int i = 0; i < 65; i++) send_byte(i[7:0]);
        check("wrap_load_cnt_loading", load_cnt, 7'd64);
        set_ld(1'b0);
        check_mem(6'h00, 8'h40);
        check_mem(6'h01, 8'h01);
        check_mem(6'h3F, 8'h3F);
        check("wrap_load_cnt", load_cnt, 7'd64);
        check("wrap_out_port", out_port, 8'hA5);
        sweep();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Program/data memory for the 6-bit-address, 8-bit-data SEL0628 processor core, with a serial byte loader and a memory-mapped output port. It sits directly downstream of the core's memory bus: it consumes `addr`, `we` and `data_out`, and returns `data_in`. While the external load pin is high, it holds the core in reset and fills memory from a slow two-wire serial stream, starting at address 0. Address 0x3F is mirrored into an output register that drives chip pins.

## Interface
Parameters:
- `DEPTH`, 64: memory words; fixed to 2^6 to match the core's address width.
- `OUT_ADDR`, 6'h3F: address mirrored into `out_port`.

Ports:
- `clk` — in, 1: system clock; all state is rising-edge.
- `clr_n` — in, 1: reset, asynchronous, active-low.
- `ld_mode` — in, 1: asynchronous pin; 1 = loader owns memory.
- `ser_clk` — in, 1: asynchronous serial bit clock; data is sampled on its rising edge.
- `ser_data` — in, 1: asynchronous serial data, MSB first.
- `cpu_addr` — in, 6: core address (core `addr`).
- `cpu_we` — in, 1: core write strobe (core `we`).
- `cpu_wdata` — in, 8: core write data (core `data_out`).
- `cpu_rdata` — out, 8: read data to the core (`data_in`); combinational `mem[cpu_addr]`.
- `cpu_clr_n` — out, 1: registered reset to the core; low while loading.
- `out_port` — out, 8: last value written by the core to `OUT_ADDR`.
- `load_cnt` — out, 7: bytes loaded since entering load mode; saturates at 64.
- `loading` — out, 1: synchronized `ld_mode`.

## Operation
Synchronization and reset:
- `ld_mode`, `ser_clk` and `ser_data` each pass through 2-flop synchronizers, giving `ld_s`, `sck_s` and `sd_s`.
- A third flop `sck_d` holds the previous `sck_s`.
- Edge detect: `sck_rise = sck_s & ~sck_d`.
- `clr_n` low clears asynchronously: all 64 memory words, `out_port`, `load_cnt`, the shift register, the bit counter, `load_ptr`, all synchronizer flops and `cpu_clr_n`. Every output is therefore 0 during reset, and `cpu_rdata` reads 0.

States, driven by `ld_s`:
- RUN (`ld_s`=0):
  - `cpu_we`=1 writes `cpu_wdata` to `mem[cpu_addr]` at the next edge.
  - If `cpu_addr`==`OUT_ADDR`, `out_port` updates on the same edge.
  - The serial inputs are ignored.
- LOAD (`ld_s`=1):
  - `cpu_we` is ignored; memory and `out_port` are untouched by the core.
  - Each `sck_rise` shifts `sd_s` into the LSB of the 8-bit shift register, which shifts left, and increments the 3-bit bit counter.
  - On the 8th bit (bit counter 7→0), the assembled byte {shift[6:0], sd_s} is written to `mem[load_ptr]` at the same edge.
  - On that edge, `load_ptr` increments (63 wraps to 0) and `load_cnt` increments, saturating at 64.
  - Loader writes to `OUT_ADDR` do not update `out_port`.

Transitions:
- RUN→LOAD on the cycle `ld_s` rises. That edge clears `load_ptr`, `load_cnt`, the bit counter and the shift register.
- LOAD→RUN on the cycle `ld_s` falls:
  - A partial byte (bit counter ≠ 0) is discarded; memory is not written.
  - `load_cnt` holds its final value until the next LOAD entry.

`cpu_clr_n`:
- Registered `~ld_s`. After `clr_n` releases, it becomes 1 once `ld_s` has settled to 0.
- It falls one cycle after `ld_s` rises, so the core is in reset before any loader write lands.

Boundary conditions:
- More than 64 bytes: writes wrap and overwrite from address 0; `load_cnt` stays 64.
- Core write and `OUT_ADDR` in the same cycle as `ld_s` rising: the write is dropped.
- `clr_n` asserted mid-byte: everything clears; after release the loader restarts at bit 0, address 0.

## Timing
- `ser_clk` pin rise → `sck_rise` asserted 2–3 `clk` later (synchronizer) → write/shift on the following edge.
- External constraints:
  - `ser_clk` high and low ≥ 4 `clk` each.
  - `ser_data` stable from 4 `clk` before to 4 `clk` after each `ser_clk` rise.
- `ld_mode` pin change → `ld_s`/`loading` change 2–3 cycles later → `cpu_clr_n` changes 1 cycle after that.
- Core read: `cpu_rdata` is combinational from `cpu_addr`, so zero-latency, as the core's Fetch/Exec states require.
- Core write: memory and `out_port` are visible on `cpu_rdata`/pins the cycle after `cpu_we`.
- Byte throughput is limited only by the `ser_clk` constraints: minimum 8×8 `clk` per byte.

## Test plan
- Basic load:
  - Stimulus: reset; `ld_mode`=1; shift 0xC5, 0x01, 0xA3; `ld_mode`=0.
  - Response: `mem[0..2]`=C5,01,A3; `load_cnt`=3; `cpu_clr_n` low throughout, high 3–4 cycles after `ld_mode` falls.
- Wrap/saturation:
  - Stimulus: load 65 bytes with value = index.
  - Response: `mem[0]`=0x40; `mem[1]`=0x01; `mem[63]`=0x3F; `load_cnt`=64.
- Partial byte:
  - Stimulus: load 0x55, then 5 bits of 0xFF, then drop `ld_mode`.
  - Response: `mem[0]`=0x55; `mem[1]`=0x00; `load_cnt`=1.
- Output port:
  - Stimulus: in RUN, `cpu_we`=1, `cpu_addr`=0x3F, `cpu_wdata`=0x5A.
  - Response: next cycle `out_port`=0x5A and `cpu_rdata`(0x3F)=0x5A.
  - Stimulus: in LOAD, a load targets 0x3F.
  - Response: `out_port` unchanged.
- Write blocking:
  - Stimulus: `cpu_we`=1 to address 0x10 with `ld_mode` high.
  - Response: `mem[0x10]` unchanged.
- Reset mid-load:
  - Stimulus: assert `clr_n` after 3 bits of the second byte.
  - Response: all memory 0; `load_cnt`=0; `out_port`=0; the next load writes address 0.
